ppwm_multi: RTL



---
 rtl/ppwm_pkg.sv | 25 ++
 rtl/ppwm_frame_rx.sv | 72 +++++++
 rtl/ppwm_multi.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ppwm_pkg.sv
// rtl/ppwm_pkg.sv - shared enums and serial frame layout helpers for ppwm_multi
package ppwm_pkg;

    typedef enum logic {CMD_DUTY = 1'b0, CMD_CFG = 1'b1} cmd_e;
    typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
    typedef enum logic {RX_IDLE = 1'b0, RX_SHIFT = 1'b1} rx_state_e;

    // Frame after the start bit, MSB first: cmd | idx | value
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int payload_len(input int w, input int num_ch);
        return 1 + ch_width(num_ch) + w;
    endfunction

    function automatic int idx_lsb(input int w);
        return w;
    endfunction

    function automatic int cmd_pos(input int w, input int num_ch);
        return w + ch_width(num_ch);
    endfunction

endpackage

// File: rtl/ppwm_frame_rx.sv
// rtl/ppwm_frame_rx.sv - serial frame receiver: start detect, shift register, bit counter, commit pulse
module ppwm_frame_rx
    import ppwm_pkg::*;
#(
    parameter int W = 8,
    parameter int NUM_CH = 4,
    localparam int CH_W = ch_width(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data_i,
    output logic            valid_o,
    output cmd_e            cmd_o,
    output logic [CH_W-1:0] idx_o,
    output logic [W-1:0]    value_o
);

    localparam int P = payload_len(W, NUM_CH);
    localparam int BCW = $clog2(P);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(P - 1);

    rx_state_e      state_q, state_d;
    logic [P-2:0]   shift_q, shift_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [P-1:0]   frame;
    logic           last_bit;

    // The commit is taken combinationally from the bit being sampled so the
    // shadow registers update on the same edge as the last payload bit.
    assign last_bit = (state_q == RX_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign frame    = {shift_q, data_i};

    assign valid_o = last_bit;
    assign cmd_o   = cmd_e'(frame[cmd_pos(W, NUM_CH)]);
    assign idx_o   = frame[idx_lsb(W) +: CH_W];
    assign value_o = frame[W-1:0];

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            RX_IDLE: begin
                if (data_i) begin
                    state_d   = RX_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            RX_SHIFT: begin
                shift_d   = frame[P-2:0];
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/ppwm_multi.sv
// rtl/ppwm_multi.sv - multi-channel serially programmed PWM with shared edge/center counter
module ppwm_multi
    import ppwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_i,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              period_start_o,
    output logic              frame_done_o,
    output logic              frame_err_o
);

    localparam int W = COUNTER_WIDTH;
    localparam int CH_W = ch_width(NUM_CH);
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic            rx_valid;
    cmd_e            rx_cmd;
    logic [CH_W-1:0] rx_idx;
    logic [W-1:0]    rx_value;

    ppwm_frame_rx #(.W(W), .NUM_CH(NUM_CH)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_o (rx_valid),
        .cmd_o   (rx_cmd),
        .idx_o   (rx_idx),
        .value_o (rx_value)
    );

    logic [W-1:0]      cnt_q, cnt_d;
    logic              down_q, down_d;
    mode_e             shadow_mode_q, shadow_mode_d, active_mode_q, active_mode_d;
    logic              shadow_en_q, shadow_en_d, active_en_q, active_en_d;
    logic [W-1:0]      shadow_duty_q [NUM_CH];
    logic [W-1:0]      shadow_duty_d [NUM_CH];
    logic [W-1:0]      active_duty_q [NUM_CH];
    logic [W-1:0]      active_duty_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              period_start_q, period_start_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic              load;

    always_comb begin
        cnt_d  = cnt_q;
        down_d = down_q;
        if (!active_en_q) begin
            cnt_d  = '0;
            down_d = 1'b0;
        end else if (active_mode_q == MODE_EDGE) begin
            cnt_d  = cnt_q + 1'b1;
            down_d = 1'b0;
        end else if (!down_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = CNT_MAX - 1'b1;
                down_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == W'(1)) begin
                down_d = 1'b0;
            end
        end
    end

    // Boundary: the edge that moves the counter to 0 counting up. While
    // disabled the counter sits there, so shadows reload every cycle.
    assign load = (cnt_d == '0) && !down_d;

    always_comb begin
        shadow_duty_d = shadow_duty_q;
        shadow_mode_d = shadow_mode_q;
        shadow_en_d   = shadow_en_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        if (rx_valid) begin
            if (rx_cmd == CMD_CFG) begin
                shadow_mode_d = mode_e'(rx_value[0]);
                shadow_en_d   = rx_value[1];
                frame_done_d  = 1'b1;
            end else if (int'(rx_idx) < NUM_CH) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (int'(rx_idx) == i) begin
                        shadow_duty_d[i] = rx_value;
                    end
                end
                frame_done_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        active_duty_d = active_duty_q;
        active_mode_d = active_mode_q;
        active_en_d   = active_en_q;
        if (load) begin
            active_duty_d = shadow_duty_q;
            active_mode_d = shadow_mode_q;
            active_en_d   = shadow_en_q;
        end
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (cnt_q < active_duty_q[i]) && active_en_q;
        end
        period_start_d = (cnt_q == '0) && !down_q && active_en_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            down_q         <= 1'b0;
            shadow_mode_q  <= MODE_EDGE;
            active_mode_q  <= MODE_EDGE;
            shadow_en_q    <= 1'b1;
            active_en_q    <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty_q[i] <= '0;
                active_duty_q[i] <= '0;
            end
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            down_q         <= down_d;
            shadow_mode_q  <= shadow_mode_d;
            active_mode_q  <= active_mode_d;
            shadow_en_q    <= shadow_en_d;
            active_en_q    <= active_en_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty_q[i] <= shadow_duty_d[i];
                active_duty_q[i] <= active_duty_d[i];
            end
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            frame_done_q   <= frame_done_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign pwm_o          = pwm_q;
    assign period_start_o = period_start_q;
    assign frame_done_o   = frame_done_q;
    assign frame_err_o    = frame_err_q;

endmodule
